// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared states, op codes and counter-width helper for the bit-serial adder/subtractor
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic {OP_ADD, OP_SUB} op_t;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W = $clog2(WIDTH_DEF);
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_addsub_fa.sv
// full_adder: one-bit full adder cell used per bit by the serial datapath
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit add/subtract, one bit per clock, start/done handshake.
// Define SERIAL_ADDSUB_OVERFLOW_EN to build the signed-overflow flag; otherwise overflow is tied to 0.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = cnt_w(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic sum, cout, last, load, shift;
  op_t op;
  assign op = op_t'(op_sub);
  assign last = cnt_q == CW'(WIDTH - 1);
  assign load = (state_q == IDLE) && start;
  assign shift = state_q == SHIFT;
  full_adder u_fa (.a(sa_q[0]), .b(sb_q[0]), .c(carry_q), .sum(sum), .carry(cout));
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? SHIFT : IDLE) :
              (state_q == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    sa_d = load ? a : shift ? sa_q >> 1 : sa_q;
    sb_d = load ? ((op == OP_SUB) ? ~b : b) : shift ? sb_q >> 1 : sb_q;
    carry_d = load ? (op == OP_SUB) : shift ? cout : carry_q;
    cnt_d = load ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    res_d = shift ? {sum, res_q[WIDTH-1:1]} : res_q;
    cout_d = (shift && last) ? cout : cout_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q <= '0;
      sb_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
    end
  end
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
  logic ovf_q;
  // carry_q is the carry into the MSB while the last bit is processed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else if (shift && last) ovf_q <= carry_q ^ cout;
  end
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif
  assign busy = shift;
  assign done = state_q == DONE;
  assign result = res_q;
  assign carry_out = cout_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and random checks of serial_addsub (WIDTH=8) against an arithmetic model
module tb_serial_addsub;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op_sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, carry_out, overflow;
  logic [W-1:0] result;
  int checks = 0, failures = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic check_model(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int sr;
    logic [W-1:0] r;
    logic cy, ov;
    r = s ? x - y : x + y;
    cy = s ? (x >= y) : (int'(x) + int'(y) > 255);
    sr = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
    ov = (sr > 127) || (sr < -128);
`else
    ov = 1'b0;
    if (sr > 1000) ov = 1'b1;
`endif
    check({tag, "_result"}, 32'(result), 32'(r));
    check({tag, "_carry"}, 32'(carry_out), 32'(cy));
    check({tag, "_ovf"}, 32'(overflow), 32'(ov));
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; op_sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    issue(x, y, s);
    check({tag, "_busy"}, 32'(busy), 1);
    wait_done(tag, W);
    check_model(tag, x, y, s);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_carry", 32'(carry_out), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    run_op("add", 8'h3C, 8'h05, 1'b0);
    run_op("wrap", 8'hFF, 8'h01, 1'b0);
    run_op("sub_borrow", 8'h05, 8'h07, 1'b1);
    run_op("sub_ok", 8'h07, 8'h05, 1'b1);
    run_op("ovf", 8'h7F, 8'h01, 1'b0);
    run_op("sub_ovf", 8'h80, 8'h01, 1'b1);
    // start pulsed mid-operation must be ignored
    issue(8'h12, 8'h34, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", W - 3);
    check_model("busy_start", 8'h12, 8'h34, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("busy_start_idle", 32'(busy), 0);
    end
    // reset mid-operation
    issue(8'h9A, 8'h0B, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_result", 32'(result), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 8'h21, 8'h43, 1'b0);
    for (int i = 0; i < 25; i++)
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
